// File: rtl/truth_table_checker.sv
// Clocked stimulus-and-compare engine: sweeps an N-bit vector through all 2^N values,
// compares two candidate responses after each vector settles, and reports the result.
module truth_table_checker #(
    parameter int unsigned N      = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         resp_a,
    input  logic         resp_b,
    output logic [N-1:0] x,
    output logic         busy,
    output logic         done,
    output logic         equal,
    output logic [N:0]   mismatch_count,
    output logic [N-1:0] first_mismatch,
    output logic         first_valid
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_settle;
    logic [N-1:0]  r_x;
    logic          r_busy;
    logic          r_done;
    logic          r_equal;
    logic [N:0]    r_count;
    logic [N-1:0]  r_first;
    logic          r_first_valid;

    logic          w_mis;
    logic [N:0]    w_count_nxt;

    // Case-inequality so an X or Z on either response counts as a disagreement.
    assign w_mis       = (resp_a !== resp_b);
    assign w_count_nxt = r_count + {{N{1'b0}}, w_mis};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_settle      <= '0;
            r_x           <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_equal       <= 1'b0;
            r_count       <= '0;
            r_first       <= '0;
            r_first_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_APPLY;
                        r_settle      <= '0;
                        r_x           <= '0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_equal       <= 1'b0;
                        r_count       <= '0;
                        r_first       <= '0;
                        r_first_valid <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_settle <= '0;
                        r_state  <= S_SAMPLE;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (w_mis) begin
                        r_count <= w_count_nxt;
                        if (!r_first_valid) begin
                            r_first       <= r_x;
                            r_first_valid <= 1'b1;
                        end
                    end
                    // x stops at all-ones rather than wrapping, so it shows the last vector.
                    if (r_x == '1) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_equal <= (w_count_nxt == '0);
                    end else begin
                        r_x     <= r_x + 1'b1;
                        r_state <= S_APPLY;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x              = r_x;
    assign busy           = r_busy;
    assign done           = r_done;
    assign equal          = r_equal;
    assign mismatch_count = r_count;
    assign first_mismatch = r_first;
    assign first_valid    = r_first_valid;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: two instances (N=2/SETTLE=1 and N=3/SETTLE=2)
// driven with directed Boolean function pairs; expected results queued at each start.
module tb_truth_table_checker;

    typedef struct {
        int unsigned cnt;
        int unsigned first;
        int unsigned fv;
        int unsigned eq;
        int unsigned at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned checks = 0;
    int unsigned errors = 0;

    exp_t q2[$];
    exp_t q3[$];

    // N=2, SETTLE=1 instance
    logic       rs2 = 1'b1, st2 = 1'b0, ra2, rb2;
    logic [1:0] x2, fm2;
    logic [2:0] mc2;
    logic       busy2, done2, eq2, fv2;
    int         mode2 = 0;
    logic       xval = 1'bx;

    // N=3, SETTLE=2 instance
    logic       rs3 = 1'b1, st3 = 1'b0, ra3, rb3;
    logic [2:0] x3, fm3;
    logic [3:0] mc3;
    logic       busy3, done3, eq3, fv3;

    truth_table_checker #(.N(2), .SETTLE(1)) dut2 (
        .clk(clk), .reset(rs2), .start(st2), .resp_a(ra2), .resp_b(rb2),
        .x(x2), .busy(busy2), .done(done2), .equal(eq2),
        .mismatch_count(mc2), .first_mismatch(fm2), .first_valid(fv2)
    );

    truth_table_checker #(.N(3), .SETTLE(2)) dut3 (
        .clk(clk), .reset(rs3), .start(st3), .resp_a(ra3), .resp_b(rb3),
        .x(x3), .busy(busy3), .done(done3), .equal(eq3),
        .mismatch_count(mc3), .first_mismatch(fm3), .first_valid(fv3)
    );

    always_comb begin
        ra2 = 1'b0;
        rb2 = 1'b0;
        case (mode2)
            0: begin ra2 = ~x2[1] | x2[0]; rb2 = x2[1] | x2[0]; end
            1: begin ra2 = x2[1] & x2[0];  rb2 = x2[1] & x2[0]; end
            2: begin ra2 = 1'b1;           rb2 = xval;          end
            3: begin ra2 = x2[0];          rb2 = x2[1];         end
            default: begin ra2 = 1'b0;     rb2 = 1'b1;          end
        endcase
    end

    always_comb begin
        ra3 = (x3[2] & x3[1]) | (x3[2] & x3[0]) | (x3[1] & x3[0]);
        rb3 = ra3 ^ (x3 == 3'b101);
    end

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic done2_q = 1'b0;
    always @(negedge clk) begin
        if (done2 && !done2_q) begin
            if (q2.size() == 0) begin
                chk("n2 unexpected done", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("n2 done edge", cyc, e.at);
                chk("n2 mismatch_count", mc2, e.cnt);
                chk("n2 first_mismatch", fm2, e.first);
                chk("n2 first_valid", fv2, e.fv);
                chk("n2 equal", eq2, e.eq);
                chk("n2 busy at done", busy2, 0);
            end
        end
        done2_q = done2;
    end

    logic done3_q = 1'b0;
    always @(negedge clk) begin
        if (done3 && !done3_q) begin
            if (q3.size() == 0) begin
                chk("n3 unexpected done", 1, 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("n3 done edge", cyc, e.at);
                chk("n3 mismatch_count", mc3, e.cnt);
                chk("n3 first_mismatch", fm3, e.first);
                chk("n3 first_valid", fv3, e.fv);
                chk("n3 equal", eq3, e.eq);
                chk("n3 x holds last", x3, 7);
            end
        end
        done3_q = done3;
    end

    task automatic wait_empty(input string nm);
        int unsigned n;
        n = 0;
        while ((q2.size() != 0 || q3.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({nm, " timeout"}, 1, 0);
        @(negedge clk);
    endtask

    // One start pulse on the N=2 instance; done expected at k+8.
    task automatic run2(input string nm, input int m, input int unsigned cnt,
                        input int unsigned first, input int unsigned fv, input int unsigned eq);
        exp_t e;
        @(negedge clk);
        mode2 = m;
        st2   = 1'b1;
        e = '{cnt: cnt, first: first, fv: fv, eq: eq, at: cyc + 1 + 8};
        q2.push_back(e);
        @(negedge clk);
        st2 = 1'b0;
        wait_empty(nm);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int unsigned k;
        repeat (3) @(negedge clk);
        rs2 = 1'b0;
        rs3 = 1'b0;
        chk("reset x", x2, 0);
        chk("reset busy", busy2, 0);
        chk("reset done", done2, 0);
        chk("reset equal", eq2, 0);
        chk("reset count", mc2, 0);
        chk("reset first", fm2, 0);
        chk("reset first_valid", fv2, 0);

        run2("implication vs or", 0, 2, 0, 1, 0);
        run2("identical and", 1, 0, 0, 0, 1);
        run2("x0 vs x1", 3, 2, 1, 1, 0);
        // X on resp_b: a 4-state simulator sees a mismatch every vector; a 2-state one resolves it.
        if ($isunknown(xval) || xval == 1'b0) run2("resp_b unknown", 2, 4, 0, 1, 0);
        else                                  run2("resp_b unknown", 2, 0, 0, 0, 1);

        // N=3 majority vs majority with 101 inverted; done at k+24
        @(negedge clk);
        st3 = 1'b1;
        e = '{cnt: 1, first: 5, fv: 1, eq: 0, at: cyc + 1 + 24};
        q3.push_back(e);
        @(negedge clk);
        st3 = 1'b0;
        wait_empty("majority n3");

        // start re-pulsed at k+3 is ignored
        @(negedge clk);
        mode2 = 0;
        st2 = 1'b1;
        k = cyc + 1;
        e = '{cnt: 2, first: 0, fv: 1, eq: 0, at: k + 8};
        q2.push_back(e);
        @(negedge clk);
        st2 = 1'b0;
        repeat (2) @(negedge clk);
        st2 = 1'b1;
        @(negedge clk);
        st2 = 1'b0;
        chk("repulse x steps", x2, 1);
        chk("repulse busy", busy2, 1);
        wait_empty("repulse");

        // reset asserted at k+5 mid-sweep
        @(negedge clk);
        mode2 = 0;
        st2 = 1'b1;
        @(negedge clk);
        st2 = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset count", mc2, 1);
        rs2 = 1'b1;
        @(negedge clk);
        rs2 = 1'b0;
        chk("midreset x", x2, 0);
        chk("midreset busy", busy2, 0);
        chk("midreset done", done2, 0);
        chk("midreset count", mc2, 0);
        chk("midreset first_valid", fv2, 0);
        repeat (12) @(negedge clk);
        chk("midreset stays idle", busy2, 0);
        run2("after reset", 0, 2, 0, 1, 0);

        // start held high: done lasts one cycle, next sweep accepted right after
        @(negedge clk);
        mode2 = 3;
        st2 = 1'b1;
        k = cyc + 1;
        e = '{cnt: 2, first: 1, fv: 1, eq: 0, at: k + 8};
        q2.push_back(e);
        e = '{cnt: 2, first: 1, fv: 1, eq: 0, at: k + 17};
        q2.push_back(e);
        repeat (10) @(negedge clk);
        st2 = 1'b0;
        chk("held start done pulse", done2, 0);
        chk("held start busy again", busy2, 1);
        chk("held start x restarts", x2, 0);
        wait_empty("held start");

        // reset and start on the same edge: reset wins
        @(negedge clk);
        chk("done before reset+start", done2, 1);
        rs2 = 1'b1;
        st2 = 1'b1;
        @(negedge clk);
        rs2 = 1'b0;
        st2 = 1'b0;
        chk("reset+start busy", busy2, 0);
        chk("reset+start done", done2, 0);
        chk("reset+start count", mc2, 0);
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
